// File: rtl/edge_pulse_meter_if.sv
// rtl/edge_pulse_meter_if.sv - measurement result channel between meter and readout logic
interface edge_pulse_meter_if #(
   parameter int CNT_W = 16
);
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             sat;

   modport master (
      output meas_valid,
      output high_cnt,
      output period_cnt,
      output sat,
      input  meas_ready
   );

   modport slave (
      input  meas_valid,
      input  high_cnt,
      input  period_cnt,
      input  sat,
      output meas_ready
   );
endinterface

// File: rtl/edge_pulse_meter.sv
// rtl/edge_pulse_meter.sv - high-time and period meter driven by rise/down edge pulses
module edge_pulse_meter #(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                rise,
   input  logic                down,
   input  logic                clr_flags,
   edge_pulse_meter_if.master  res,
   output logic                dropped,
   output logic                proto_err,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] high_lat;
   logic [CNT_W-1:0] cnt_inc;
   logic             ev_both;
   logic             ev_rise;
   logic             ev_down;
   logic             complete;
   logic             out_free;

   // Coincident rise and down are treated as no event at all.
   assign ev_both  = rise & down;
   assign ev_rise  = rise & ~down;
   assign ev_down  = down & ~rise;
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   assign complete = enable && (state == LOW) && ev_rise;
   assign out_free = !res.meas_valid || res.meas_ready;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         high_lat   <= '0;
         busy       <= 1'b0;
      end else if (!enable) begin
         state      <= IDLE;
         cnt        <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= ARM;
               busy  <= 1'b0;
            end
            ARM: begin
               if (ev_rise) begin
                  state <= HIGH;
                  cnt   <= CNT_ONE;
                  busy  <= 1'b1;
               end
            end
            HIGH: begin
               busy <= 1'b1;
               if (ev_down) begin
                  high_lat <= cnt;
                  cnt      <= cnt_inc;
                  state    <= LOW;
               end else if (ev_rise) begin
                  cnt <= CNT_ONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            LOW: begin
               busy <= 1'b1;
               if (ev_rise) begin
                  cnt   <= CNT_ONE;
                  state <= HIGH;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Result register: data fields only change when a new result is accepted.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         res.meas_valid <= 1'b0;
         res.high_cnt   <= '0;
         res.period_cnt <= '0;
         res.sat        <= 1'b0;
      end else if (complete && out_free) begin
         res.meas_valid <= 1'b1;
         res.high_cnt   <= high_lat;
         res.period_cnt <= cnt;
         res.sat        <= (high_lat == CNT_MAX) || (cnt == CNT_MAX);
      end else if (res.meas_valid && res.meas_ready) begin
         res.meas_valid <= 1'b0;
      end
   end

   // Sticky flags: a set in the same cycle as clr_flags wins.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         dropped   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (clr_flags) begin
            dropped   <= 1'b0;
            proto_err <= 1'b0;
         end
         if (complete && !out_free) begin
            dropped <= 1'b1;
         end
         if (ev_both) begin
            proto_err <= 1'b1;
         end
      end
   end
endmodule

// File: doc/edge_pulse_meter.md
Name: edge_pulse_meter

Overview:
Downstream consumer of the edge detector's single-cycle rise/down pulses. It measures the high time and the period of the monitored signal in clk cycles, running continuously from one rise to the next. Each completed measurement is presented on a valid/ready output register for the debug/readout logic.

Parameters:
CNT_W, 16, width of the cycle counter and of both result fields.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-high (asserted when rst_n=1)
enable  input  1  measurement enable; 0 forces IDLE
rise  input  1  single-cycle rising-edge pulse from the edge detector
down  input  1  single-cycle falling-edge pulse from the edge detector
meas_ready  input  1  consumer accepts the result
clr_flags  input  1  synchronous clear of the sticky flags
meas_valid  output  1  result registers hold an unconsumed measurement
high_cnt  output  CNT_W  cycles from rise to down
period_cnt  output  CNT_W  cycles from rise to the next rise
sat  output  1  this result saturated (either field equals 2^CNT_W-1)
dropped  output  1  sticky: a result was lost because the output was full
proto_err  output  1  sticky: rise and down were both asserted in one cycle
busy  output  1  state is HIGH or LOW

Behaviour:
- Reset: the reset is asynchronous, active-high, on clk. While rst_n=1: meas_valid=0, high_cnt=0, period_cnt=0, sat=0, dropped=0, proto_err=0, busy=0, state=IDLE, internal counter=0.
- A reset asserted mid-measurement discards the partial measurement and any pending result.
- States: IDLE, ARM, HIGH, LOW.
- IDLE: enable=1 -> ARM on the next cycle.
- From any state, enable=0 -> IDLE and counter cleared. A pending output result is kept until it is handshaken.
- ARM: rise -> HIGH with cnt<=1. down is ignored.
- HIGH: each cycle with no event, cnt<=cnt+1, saturating at all-ones. A saturated count sets an internal sat_pend flag.
  - down: latch high_lat<=cnt, cnt<=cnt+1, go to LOW.
  - rise (down was missed): restart with cnt<=1, sat_pend cleared, stay in HIGH. No result is produced.
- LOW: each cycle with no event, cnt<=cnt+1, saturating.
  - rise: measurement complete with period=cnt, high=high_lat.
  - On the same edge, the next measurement starts: cnt<=1, go to HIGH (back-to-back, no dead cycle).
  - down in LOW is ignored.
- Example timing: rise sampled at edge N and down sampled at edge N+k gives high=k. The next rise sampled at edge N+p gives period=p.
- Output register:
  - On completion, if meas_valid=0 or meas_ready=1 in that cycle: load high_cnt, period_cnt and sat; meas_valid=1 from the next cycle.
  - Otherwise the new result is discarded and dropped<=1.
  - meas_valid&&meas_ready with no new completion -> meas_valid<=0. Data fields hold their last value.
  - Output data is stable while meas_valid=1 and meas_ready=0.
- Latency: the result is visible the cycle after the terminating rise is sampled.
- rise&&down in the same cycle, in any state: both are ignored (counting continues), proto_err<=1.
- clr_flags=1 clears dropped and proto_err. If a set event happens in the same cycle, the set wins.
- Width rule: counter saturates at 2^CNT_W-1 and never wraps. sat=1 if high or period saturated.

Test Plan:
- Reset/idle: rst_n=1 with toggling inputs -> all outputs 0. Release with enable=1 -> busy=0 until the first rise.
- Basic: rise@10, down@13, rise@20, meas_ready=1 -> meas_valid=1 for one cycle at edge 21 with high_cnt=3, period_cnt=10, sat=0. busy remains 1.
- Backpressure/drop: meas_ready=0, two back-to-back measurements (period 5, high 2) -> first result held stable, second discarded, dropped=1. clr_flags pulse -> dropped=0.
- Saturation: CNT_W=4, rise, down after 20 cycles, rise after 30 cycles -> high_cnt=15, period_cnt=15, sat=1.
- Glitch/protocol: rise@5, rise@8, down@10, rise@15 -> high_cnt=2, period_cnt=7. rise&&down same cycle -> proto_err=1, counting unaffected.
- Mid-operation abort: enable=0 in HIGH -> IDLE, no result. Reset asserted in LOW with a pending valid -> meas_valid=0 immediately (asynchronous).
